dma_axi_slave_bridge: RTL and testbench
=======================================

DMA_AXI_SLAVE_BRIDGE -- requirements
Module: dma_axi_slave_bridge

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 11, meaning row-address width of the lane memory request port.
REQ-002 SHALL have parameter NUMLANES, default 8, meaning number of memory lanes per row.
REQ-003 SHALL have parameter WIDTH, default 16, meaning bits per lane.
REQ-004 SHALL have parameter READ_LATENCY, default 1, meaning cycles from request to valid read data (range 1..4).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s_axi_awaddr/awvalid/awready  in/in/out  32/1/1  AXI4-Lite write address channel.
REQ-008 s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  NUMLANES*WIDTH / NUMLANES*WIDTH/8 / 1 / 1  write data channel.
REQ-009 s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-010 s_axi_araddr/arvalid/arready  in/in/out  32/1/1  read address channel.
REQ-011 s_axi_rdata/rresp/rvalid/rready  out/out/out/in  NUMLANES*WIDTH/2/1/1  read data channel.
REQ-012 axi_addr  output  ADDRWIDTH  row address to lane-memory mux.
REQ-013 axi_data  output  NUMLANES*WIDTH  write row to mux.
REQ-014 axi_req_en  output  1  one-cycle memory request strobe.
REQ-015 axi_req_type  output  1  1=write, 0=read.
REQ-016 axi_read_data  input  NUMLANES*WIDTH  row read data from mux, valid READ_LATENCY cycles after read strobe.

Function
REQ-017 Row address SHALL be byte address bits [ADDRWIDTH+OFS-1:OFS], OFS=log2(NUMLANES*WIDTH/8); upper and lower bits ignored.
REQ-018 One transaction outstanding at a time; FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
REQ-019 In IDLE, awready=1 while AW not yet latched; wready=1 while W not yet latched; AW and W accepted in either order or same cycle.
REQ-020 In IDLE, arready=1 only when neither AW nor W is latched and no write is ready to issue.
REQ-021 IDLE->WR_REQ when both AW and W latched; IDLE->RD_REQ on AR handshake.
REQ-022 If write becomes complete in the same cycle arvalid is high with nothing latched, priority SHALL alternate via a one-bit toggle, read favoured after reset.
REQ-023 WR_REQ: if wstrb all ones, drive axi_req_en=1, axi_req_type=1, axi_addr, axi_data for exactly one cycle, bresp=OKAY; else no strobe, bresp=SLVERR; then WR_RESP.
REQ-024 WR_RESP: bvalid=1 until bready; then IDLE, latches cleared.
REQ-025 RD_REQ: axi_req_en=1, axi_req_type=0 one cycle; RD_WAIT counts READ_LATENCY cycles, then capture axi_read_data into rdata register; RD_RESP.
REQ-026 RD_RESP: rvalid=1, rresp=OKAY, rdata stable until rready; then IDLE.
REQ-027 axi_req_en SHALL be 0 in all states other than WR_REQ (full strobe) and RD_REQ; axi_data/axi_addr are don't-care when axi_req_en=0 but SHALL be registered.
REQ-028 Total latency AR handshake to rvalid = READ_LATENCY+2 cycles; W/AW completion to bvalid = 2 cycles.
REQ-029 Stalled bready/rready SHALL hold all response outputs stable indefinitely.

Reset
REQ-030 On reset: state IDLE, all latches cleared, priority toggle=read, awready/wready/arready=0 during reset cycle, bvalid=rvalid=axi_req_en=0, bresp=rresp=0, rdata=0, axi_addr=0, axi_data=0, axi_req_type=0.
REQ-031 Reset mid-transaction SHALL abandon it with no further memory strobe or response.

Structure
REQ-032 State enum and AXI response codes (OKAY=2'b00, SLVERR=2'b10) SHALL live in shared package dma_axi_pkg.
REQ-033 Single module; no sub-module; READ_LATENCY counter inline.

Verification
REQ-034 Write awaddr=0x40, wdata=row A, wstrb all ones, AW before W by 3 cycles -> one axi_req_en cycle, type=1, axi_addr=4, axi_data=A; bvalid with OKAY 2 cycles later.
REQ-035 Read araddr=0x40, READ_LATENCY=2, axi_read_data=A at strobe+2 -> rvalid at handshake+4, rdata=A, rresp=OKAY.
REQ-036 wstrb=0x00FF -> no axi_req_en, bresp=SLVERR.
REQ-037 Simultaneous complete write and arvalid after reset -> read served first, write next; repeat -> order alternates.
REQ-038 Hold rready=0 for 10 cycles -> rdata/rvalid stable, arready=0 throughout.
REQ-039 Assert reset during RD_WAIT -> no rvalid, outputs at reset values, next read completes normally.

Source files
------------

// File: rtl/dma_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_axi_pkg
// Description : Shared types and constants for the DMA AXI4-Lite slave bridge.
//               Holds the bridge FSM state encoding and the AXI response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_RESP = 3'd5
    } state_e;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

endpackage : dma_axi_pkg
`default_nettype wire

// File: rtl/dma_axi_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dma_axi_slave_bridge
// Description : AXI4-Lite slave that turns single-beat row writes/reads into
//               one-cycle requests on a lane-memory mux port. One transaction
//               is outstanding at a time.
// Ports       : clk/reset             - clock, synchronous active-high reset
//               s_axi_aw*/w*/b*       - AXI4-Lite write address/data/response
//               s_axi_ar*/r*          - AXI4-Lite read address/data
//               axi_addr/axi_data     - registered row address / write row
//               axi_req_en/_type      - one-cycle request strobe, 1=write
//               axi_read_data         - row data, valid READ_LATENCY cycles
//                                       after a read strobe
// Revision    : 1.0 - initial release
// ============================================================================
module dma_axi_slave_bridge
    import dma_axi_pkg::*;
#(
    parameter int ADDRWIDTH    = 11,
    parameter int NUMLANES     = 8,
    parameter int WIDTH        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [NUMLANES*WIDTH-1:0]     s_axi_wdata,
    input  logic [NUMLANES*WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [31:0]                   s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [NUMLANES*WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [ADDRWIDTH-1:0]          axi_addr,
    output logic [NUMLANES*WIDTH-1:0]     axi_data,
    output logic                          axi_req_en,
    output logic                          axi_req_type,
    input  logic [NUMLANES*WIDTH-1:0]     axi_read_data
);

    localparam int ROWBITS = NUMLANES * WIDTH;
    localparam int OFS     = $clog2(ROWBITS / 8);

    state_e               state_q, state_d;
    logic                 aw_lat_q, aw_lat_d;
    logic                 w_lat_q, w_lat_d;
    logic [ADDRWIDTH-1:0] aw_row_q, aw_row_d;
    logic [ROWBITS-1:0]   wdata_q, wdata_d;
    logic                 wfull_q, wfull_d;
    logic                 wr_ok_q, wr_ok_d;
    logic                 prio_q, prio_d;      // 0: read wins a tie, 1: write wins
    logic [1:0]           rd_cnt_q, rd_cnt_d;

    logic                 req_en_q, req_type_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [ROWBITS-1:0]   data_q;
    logic                 bvalid_q, rvalid_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [ROWBITS-1:0]   rdata_q;

    logic                 w_idle, w_none_latched, w_both_wr_valid, w_conflict;
    logic                 w_arready, w_awready, w_wready;
    logic                 w_ar_hs, w_aw_hs, w_w_hs, w_wr_go, w_wr_full, w_rd_last;
    logic [ADDRWIDTH-1:0] w_aw_row, w_ar_row, w_wr_row;
    logic [ROWBITS-1:0]   w_wr_data;
    logic                 w_unused_addr_bits;

    assign w_aw_row = s_axi_awaddr[ADDRWIDTH+OFS-1:OFS];
    assign w_ar_row = s_axi_araddr[ADDRWIDTH+OFS-1:OFS];
    assign w_unused_addr_bits = ^{s_axi_awaddr[31:ADDRWIDTH+OFS], s_axi_awaddr[OFS-1:0],
                                  s_axi_araddr[31:ADDRWIDTH+OFS], s_axi_araddr[OFS-1:0]};

    // Ready terms are gated by reset so the bus sees no acceptance during reset.
    assign w_idle          = (state_q == ST_IDLE) && !reset;
    assign w_none_latched  = !aw_lat_q && !w_lat_q;
    assign w_both_wr_valid = s_axi_awvalid && s_axi_wvalid;
    // A tie: a whole write and a read both offered with nothing captured yet.
    assign w_conflict      = w_idle && w_none_latched && w_both_wr_valid && s_axi_arvalid;

    assign w_arready = w_idle && w_none_latched && !(w_both_wr_valid && prio_q);
    assign w_ar_hs   = w_arready && s_axi_arvalid;
    // Taking a read this cycle blocks write acceptance so the write stays on the bus.
    assign w_awready = w_idle && !aw_lat_q && !w_ar_hs;
    assign w_wready  = w_idle && !w_lat_q && !w_ar_hs;
    assign w_aw_hs   = w_awready && s_axi_awvalid;
    assign w_w_hs    = w_wready && s_axi_wvalid;
    assign w_wr_go   = w_idle && (aw_lat_q || w_aw_hs) && (w_lat_q || w_w_hs);

    // Bypass the capture registers when the last half arrives in the go cycle.
    assign w_wr_row  = w_aw_hs ? w_aw_row : aw_row_q;
    assign w_wr_data = w_w_hs ? s_axi_wdata : wdata_q;
    assign w_wr_full = w_w_hs ? (&s_axi_wstrb) : wfull_q;
    assign w_rd_last = (rd_cnt_q == 2'(READ_LATENCY - 1));

    always_comb begin
        state_d  = state_q;
        aw_lat_d = aw_lat_q;
        w_lat_d  = w_lat_q;
        aw_row_d = aw_row_q;
        wdata_d  = wdata_q;
        wfull_d  = wfull_q;
        wr_ok_d  = wr_ok_q;
        prio_d   = prio_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    aw_lat_d = 1'b1;
                    aw_row_d = w_aw_row;
                end
                if (w_w_hs) begin
                    w_lat_d = 1'b1;
                    wdata_d = s_axi_wdata;
                    wfull_d = &s_axi_wstrb;
                end
                if (w_conflict) begin
                    prio_d = !prio_q;
                end
                if (w_ar_hs) begin
                    state_d = ST_RD_REQ;
                end else if (w_wr_go) begin
                    wr_ok_d = w_wr_full;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (s_axi_bready) begin
                    aw_lat_d = 1'b0;
                    w_lat_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                rd_cnt_d = 2'd0;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_rd_last) begin
                    state_d = ST_RD_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            ST_RD_RESP: begin
                if (s_axi_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            aw_row_q   <= '0;
            wdata_q    <= '0;
            wfull_q    <= 1'b0;
            wr_ok_q    <= 1'b0;
            prio_q     <= 1'b0;
            rd_cnt_q   <= 2'd0;
            req_en_q   <= 1'b0;
            req_type_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= c_RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= c_RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            state_q  <= state_d;
            aw_lat_q <= aw_lat_d;
            w_lat_q  <= w_lat_d;
            aw_row_q <= aw_row_d;
            wdata_q  <= wdata_d;
            wfull_q  <= wfull_d;
            wr_ok_q  <= wr_ok_d;
            prio_q   <= prio_d;
            rd_cnt_q <= rd_cnt_d;

            // Request outputs are loaded on entry so the strobe lines up with
            // the WR_REQ / RD_REQ state cycle.
            req_en_q <= 1'b0;
            if (w_wr_go && !w_ar_hs && w_wr_full) begin
                req_en_q   <= 1'b1;
                req_type_q <= 1'b1;
                addr_q     <= w_wr_row;
                data_q     <= w_wr_data;
            end
            if (w_ar_hs) begin
                req_en_q   <= 1'b1;
                req_type_q <= 1'b0;
                addr_q     <= w_ar_row;
            end

            if (state_q == ST_WR_REQ) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok_q ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if ((state_q == ST_WR_RESP) && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if ((state_q == ST_RD_WAIT) && w_rd_last) begin
                rvalid_q <= 1'b1;
                rresp_q  <= c_RESP_OKAY;
                rdata_q  <= axi_read_data;
            end else if ((state_q == ST_RD_RESP) && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = w_awready;
    assign s_axi_wready  = w_wready;
    assign s_axi_arready = w_arready;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign axi_req_en    = req_en_q;
    assign axi_req_type  = req_type_q;
    assign axi_addr      = addr_q;
    assign axi_data      = data_q;

endmodule : dma_axi_slave_bridge
`default_nettype wire

// File: tb/tb_dma_axi_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_axi_slave_bridge
// Description : Self-checking bench for dma_axi_slave_bridge with a
//               transaction-level model (expected strobe queue, expected
//               memory image, tie-break toggle) and a lane-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_axi_slave_bridge;

    localparam int AW = 11;
    localparam int NL = 8;
    localparam int WD = 16;
    localparam int RL = 2;
    localparam int DW = NL * WD;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   s_axi_awaddr, s_axi_araddr;
    logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [DW-1:0] s_axi_wdata, s_axi_rdata, axi_data, axi_read_data;
    logic [SW-1:0] s_axi_wstrb;
    logic [1:0]    s_axi_bresp, s_axi_rresp;
    logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic          s_axi_rvalid, s_axi_rready, axi_req_en, axi_req_type;
    logic [AW-1:0] axi_addr;

    dma_axi_slave_bridge #(
        .ADDRWIDTH(AW), .NUMLANES(NL), .WIDTH(WD), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .axi_addr(axi_addr), .axi_data(axi_data), .axi_req_en(axi_req_en),
        .axi_req_type(axi_req_type), .axi_read_data(axi_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct { bit typ; logic [AW-1:0] addr; logic [DW-1:0] data; } strb_t;
    typedef struct { int due; logic [AW-1:0] addr; } rdp_t;
    strb_t exp_q[$];
    rdp_t  rd_pend[$];
    strb_t e;
    logic [DW-1:0] dev_mem [0:2047];
    logic [DW-1:0] exp_mem [0:2047];
    bit            model_prio;       // 0: read wins the next tie
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    logic          prev_rvalid, prev_rready, prev_bvalid, prev_bready, prev_reset;
    logic [DW-1:0] prev_rdata;
    logic [1:0]    prev_rresp, prev_bresp;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out, required a response within budget (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [AW-1:0] row_of(input logic [31:0] a);
        return AW'((a >> 4) & 32'h7FF);   // 16-byte rows, 11-bit row index
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (s == {SW{1'b1}}) begin
            exp_q.push_back('{1'b1, row_of(a), d});
            exp_mem[row_of(a)] = d;
        end
    endtask

    task automatic model_read(input logic [31:0] a);
        exp_q.push_back('{1'b0, row_of(a), '0});
    endtask

    // Lane-memory responder and per-cycle output checker.
    always @(negedge clk) begin
        if (axi_req_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_strobe: got strobe type=%0d addr=%0d, required none (cycle %0d)",
                         axi_req_type, axi_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_type", DW'(axi_req_type), DW'(e.typ));
                chk("strobe_addr", DW'(axi_addr), DW'(e.addr));
                if (e.typ) chk("strobe_data", axi_data, e.data);
            end
            if (axi_req_type) begin
                dev_mem[axi_addr] = axi_data;
                last_wr_addr = axi_addr;
                last_wr_data = axi_data;
            end else begin
                rd_pend.push_back('{cyc + RL, axi_addr});
            end
        end
        while (rd_pend.size() > 0 && rd_pend[0].due < cyc) void'(rd_pend.pop_front());
        if (rd_pend.size() > 0 && rd_pend[0].due == cyc) begin
            axi_read_data = dev_mem[rd_pend[0].addr];
            void'(rd_pend.pop_front());
        end else begin
            axi_read_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (prev_rvalid && !prev_rready && !prev_reset) begin
            chk("rvalid_hold", DW'(s_axi_rvalid), 1);
            chk("rdata_hold", s_axi_rdata, prev_rdata);
            chk("rresp_hold", DW'(s_axi_rresp), DW'(prev_rresp));
            chk("arready_in_rresp", DW'(s_axi_arready), 0);
        end
        if (prev_bvalid && !prev_bready && !prev_reset) begin
            chk("bvalid_hold", DW'(s_axi_bvalid), 1);
            chk("bresp_hold", DW'(s_axi_bresp), DW'(prev_bresp));
        end
        prev_rvalid = s_axi_rvalid;  prev_rready = s_axi_rready;  prev_rdata = s_axi_rdata;
        prev_rresp  = s_axi_rresp;   prev_bvalid = s_axi_bvalid;  prev_bready = s_axi_bready;
        prev_bresp  = s_axi_bresp;   prev_reset  = reset;
    end

    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a, output int hs);
        int budget = 0;
        hs = -1;
        s_axi_awaddr = a;
        s_axi_awvalid = 1'b1;
        forever begin
            #1;
            if (s_axi_awready) begin hs = cyc; break; end
            budget++;
            if (budget > 100) break;
            wait_cyc();
        end
        if (hs < 0) timeout_fail("aw_handshake");
        wait_cyc();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, output int hs);
        int budget = 0;
        hs = -1;
        s_axi_wdata = d;
        s_axi_wstrb = s;
        s_axi_wvalid = 1'b1;
        forever begin
            #1;
            if (s_axi_wready) begin hs = cyc; break; end
            budget++;
            if (budget > 100) break;
            wait_cyc();
        end
        if (hs < 0) timeout_fail("w_handshake");
        wait_cyc();
        s_axi_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, output int hs);
        int budget = 0;
        hs = -1;
        s_axi_araddr = a;
        s_axi_arvalid = 1'b1;
        forever begin
            #1;
            if (s_axi_arready) begin hs = cyc; break; end
            budget++;
            if (budget > 100) break;
            wait_cyc();
        end
        if (hs < 0) timeout_fail("ar_handshake");
        wait_cyc();
        s_axi_arvalid = 1'b0;
    endtask

    // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW.
    task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int gap, input int bdelay, input logic [1:0] exp_bresp,
                            output int lat);
        int aw_c, w_c, comp, budget;
        lat = -1;
        fork
            begin
                repeat ((gap < 0) ? -gap : 0) wait_cyc();
                send_aw(a, aw_c);
            end
            begin
                repeat ((gap > 0) ? gap : 0) wait_cyc();
                send_w(d, s, w_c);
            end
        join
        comp = (aw_c > w_c) ? aw_c : w_c;
        budget = 0;
        while (!s_axi_bvalid && budget < 100) begin wait_cyc(); budget++; end
        if (!s_axi_bvalid) begin
            timeout_fail("bvalid");
        end else begin
            lat = cyc - comp;
            chk("wr_bvalid_cycle", DW'(cyc), DW'(comp + 2));
            chk("wr_bresp", DW'(s_axi_bresp), DW'(exp_bresp));
        end
        repeat (bdelay) wait_cyc();
        s_axi_bready = 1'b1;
        wait_cyc();
        s_axi_bready = 1'b0;
        chk("bvalid_clear", DW'(s_axi_bvalid), 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [DW-1:0] exp_d, input int rdelay,
                           output int lat);
        int h, budget;
        lat = -1;
        send_ar(a, h);
        budget = 0;
        while (!s_axi_rvalid && budget < 100) begin wait_cyc(); budget++; end
        if (!s_axi_rvalid) begin
            timeout_fail("rvalid");
        end else begin
            lat = cyc - h;
            chk("rd_rvalid_cycle", DW'(cyc), DW'(h + RL + 2));
            chk("rd_data", s_axi_rdata, exp_d);
            chk("rd_resp", DW'(s_axi_rresp), 0);
        end
        repeat (rdelay) begin
            wait_cyc();
            chk("arready_stalled", DW'(s_axi_arready), 0);
        end
        s_axi_rready = 1'b1;
        wait_cyc();
        s_axi_rready = 1'b0;
        chk("rvalid_clear", DW'(s_axi_rvalid), 0);
    endtask

    task automatic check_reset_values();
        chk("rst_bvalid", DW'(s_axi_bvalid), 0);
        chk("rst_rvalid", DW'(s_axi_rvalid), 0);
        chk("rst_req_en", DW'(axi_req_en), 0);
        chk("rst_bresp", DW'(s_axi_bresp), 0);
        chk("rst_rresp", DW'(s_axi_rresp), 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_axi_addr", DW'(axi_addr), 0);
        chk("rst_axi_data", axi_data, 0);
        chk("rst_req_type", DW'(axi_req_type), 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        chk("rst_awready", DW'(s_axi_awready), 0);
        chk("rst_wready", DW'(s_axi_wready), 0);
        chk("rst_arready", DW'(s_axi_arready), 0);
        repeat (n) wait_cyc();
        reset = 1'b0;
        model_prio = 1'b0;
        #1;
        check_reset_values();
        wait_cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] row_a, d;
        logic [31:0]   a, r;
        logic [SW-1:0] s;
        int            lat, h, rd_first;
        row_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int i = 0; i < 2048; i++) begin
            dev_mem[i] = {4{32'(i) * 32'h9E37_79B1}};
            exp_mem[i] = dev_mem[i];
        end
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 0;  s_axi_bready = 0;  s_axi_araddr = '0; s_axi_arvalid = 0;
        s_axi_rready = 0;  axi_read_data = '0;
        prev_rvalid = 0; prev_rready = 0; prev_bvalid = 0; prev_bready = 0; prev_reset = 1;
        prev_rdata = '0; prev_rresp = '0; prev_bresp = '0;

        do_reset(3);
        chk("idle_arready", DW'(s_axi_arready), 1);
        chk("idle_awready", DW'(s_axi_awready), 1);
        chk("idle_wready", DW'(s_axi_wready), 1);

        // Full-strobe write to 0x40 with AW three cycles ahead of W.
        model_write(32'h40, row_a, 16'hFFFF);
        do_write(32'h40, row_a, 16'hFFFF, 3, 0, 2'b00, lat);
        chk("wr_latency_literal", DW'(lat), 2);
        chk("wr_addr_literal", DW'(last_wr_addr), 4);
        chk("wr_data_literal", last_wr_data, row_a);

        // Read it back.
        model_read(32'h40);
        do_read(32'h40, row_a, 0, lat);
        chk("rd_latency_literal", DW'(lat), 4);

        // Partial strobe: no memory request, SLVERR.
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_write(32'h50, d, 16'h00FF);
        do_write(32'h50, d, 16'h00FF, 0, 2, 2'b10, lat);
        chk("slverr_latency", DW'(lat), 2);

        // W ahead of AW, then a long rready stall.
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_write(32'h0000_0123, d, 16'hFFFF);
        do_write(32'h0000_0123, d, 16'hFFFF, -2, 1, 2'b00, lat);
        model_read(32'h40);
        do_read(32'h40, row_a, 10, lat);

        // Ties between a complete write and a read alternate, read first after reset.
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wa, ra;
            int lw, lr;
            wa = 32'h200 + 32'(k) * 32'h10;
            ra = 32'h300 + 32'(k) * 32'h10;
            d  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rd_first = (model_prio == 1'b0);
            if (rd_first) begin
                model_read(ra);
                model_write(wa, d, 16'hFFFF);
            end else begin
                model_write(wa, d, 16'hFFFF);
                model_read(ra);
            end
            model_prio = !model_prio;
            fork
                do_write(wa, d, 16'hFFFF, 0, 0, 2'b00, lw);
                do_read(ra, exp_mem[row_of(ra)], 1, lr);
            join
            wait_cyc();
        end

        // Reset while waiting for read data: the read is dropped.
        model_read(32'h40);
        send_ar(32'h40, h);
        wait_cyc();
        reset = 1'b1;
        #1;
        chk("midrst_awready", DW'(s_axi_awready), 0);
        chk("midrst_arready", DW'(s_axi_arready), 0);
        wait_cyc();
        reset = 1'b0;
        model_prio = 1'b0;
        check_reset_values();
        repeat (6) begin
            wait_cyc();
            chk("aborted_no_rvalid", DW'(s_axi_rvalid), 0);
        end
        model_read(32'h40);
        do_read(32'h40, row_a, 0, lat);

        // Randomised sequential traffic.
        for (int t = 0; t < 60; t++) begin
            r = $urandom();
            a = (r & 32'hFFFF_8000) | (32'($urandom_range(0, 15)) << 4) | (r & 32'hF);
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                s = ($urandom_range(0, 3) == 0) ? SW'($urandom()) : {SW{1'b1}};
                model_write(a, d, s);
                do_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)),
                         (s == {SW{1'b1}}) ? 2'b00 : 2'b10, lat);
            end else begin
                model_read(a);
                do_read(a, exp_mem[row_of(a)], int'($urandom_range(0, 3)), lat);
            end
            repeat ($urandom_range(0, 2)) wait_cyc();
        end

        repeat (4) wait_cyc();
        chk("pending_strobes", DW'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dma_axi_slave_bridge
`default_nettype wire
